// File: rtl/mem_ops_pkg.sv
// Shared definitions for the MEM-stage data-memory access path.
// Contents: load/store op codes, byte-enable constants, the access FSM
// state encoding and a helper that maps an op code to its access size.
// Op codes 101..111 are not defined and behave as word accesses.
package mem_ops_pkg;

    localparam logic [2:0] OP_W  = 3'b000;   // word
    localparam logic [2:0] OP_BU = 3'b001;   // byte, zero-extended later
    localparam logic [2:0] OP_B  = 3'b010;   // byte, sign-extended later
    localparam logic [2:0] OP_HU = 3'b011;   // half, zero-extended later
    localparam logic [2:0] OP_H  = 3'b100;   // half, sign-extended later

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    function automatic size_t op_size(input logic [2:0] op);
        case (op)
            OP_BU, OP_B: return SZ_BYTE;
            OP_HU, OP_H: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Signal bundle between the MEM pipeline stage, the access unit and the
// data bus.
//   req_*      : access request from the pipeline (held while stall=1)
//   stall      : pipeline hold
//   bus_*      : req/ack data-bus transaction
//   ld_*       : captured load result for the downstream load extender
//   exc_*      : one-cycle exception pulses (misaligned load/store, bus timeout)
// Modports: slave = access unit, master = pipeline/bus environment.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    logic [31:0] ld_word;
    logic [1:0]  ld_a;
    logic [2:0]  ld_op;
    logic        ld_valid;

    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata,
        input  bus_rdata, bus_ack,
        output stall,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output ld_word, ld_a, ld_op, ld_valid,
        output exc_adel, exc_ades, exc_bus
    );

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata,
        output bus_rdata, bus_ack,
        input  stall,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  ld_word, ld_a, ld_op, ld_valid,
        input  exc_adel, exc_ades, exc_bus
    );

endinterface

// File: rtl/mem_access_unit_store_align.sv
// store_align: combinational lane alignment for one access.
//   op_i        : access op code
//   addr_lo_i   : byte address bits [1:0]
//   wdata_i     : store data (low byte/half used for narrow stores)
//   we_i        : 1 = store, 0 = load
//   be_o        : byte enables (loads always read the full word)
//   lane_data_o : store data replicated across all byte lanes
//   misaligned_o: access violates its natural alignment
module store_align
    import mem_ops_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [3:0]  be_o,
    output logic [31:0] lane_data_o,
    output logic        misaligned_o
);

    size_t size;

    assign size = op_size(op_i);

    // Replicate the source data so every lane carries the right byte no
    // matter which lanes the byte enables select.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_data_o[8*gi +: 8] =
            (size == SZ_BYTE) ? wdata_i[7:0] :
            (size == SZ_HALF) ? wdata_i[8*(gi % 2) +: 8] :
                                wdata_i[8*gi +: 8];
    end

    always_comb begin
        be_o         = BE_WORD;
        misaligned_o = 1'b0;
        case (size)
            SZ_HALF: begin
                misaligned_o = addr_lo_i[0];
                if (we_i) begin
                    be_o = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                end
            end
            SZ_BYTE: begin
                if (we_i) begin
                    be_o = BE_BYTE0 << addr_lo_i;
                end
            end
            default: begin
                misaligned_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Turns pipeline load/store requests into req/ack bus transactions, stalls
// the pipeline until the access completes, flags misaligned accesses and
// bus timeouts, and hands the raw read word to the load extender.
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_access_unit_if.slave (request, stall, bus, load, exceptions)
// Parameter WAIT_MAX: BUSY cycles without bus_ack before a bus error.
module mem_access_unit
    import mem_ops_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_unit_if.slave      bus
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  op_q, op_d;          // op of the in-flight access
    logic [1:0]  a_q, a_d;            // address low bits of the in-flight access
    logic [31:0] ld_word_q, ld_word_d;
    logic [1:0]  ld_a_q, ld_a_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic        ld_valid_q, ld_valid_d;
    logic        exc_adel_q, exc_adel_d;
    logic        exc_ades_q, exc_ades_d;
    logic        exc_bus_q, exc_bus_d;

    logic [3:0]  al_be;
    logic [31:0] al_data;
    logic        al_misaligned;

    store_align u_store_align (
        .op_i        (bus.req_op),
        .addr_lo_i   (bus.req_addr[1:0]),
        .wdata_i     (bus.req_wdata),
        .we_i        (bus.req_we),
        .be_o        (al_be),
        .lane_data_o (al_data),
        .misaligned_o(al_misaligned)
    );

    // The DONE cycle is the one where the pipeline is released; misaligned
    // requests are reported as exceptions and never hold the pipeline.
    assign bus.stall = bus.req_valid & ~al_misaligned & (state_q != ST_DONE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        op_d        = op_q;
        a_d         = a_q;
        ld_word_d   = ld_word_q;
        ld_a_d      = ld_a_q;
        ld_op_d     = ld_op_q;
        ld_valid_d  = 1'b0;
        exc_adel_d  = 1'b0;
        exc_ades_d  = 1'b0;
        exc_bus_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (al_misaligned) begin
                        exc_adel_d = ~bus.req_we;
                        exc_ades_d = bus.req_we;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = bus.req_we;
                        bus_addr_d  = {bus.req_addr[31:2], 2'b00};
                        bus_be_d    = al_be;
                        bus_wdata_d = al_data;
                        op_d        = bus.req_op;
                        a_d         = bus.req_addr[1:0];
                        cnt_d       = '0;
                        state_d     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // An ack arriving on the final wait cycle still completes
                // the access, so it is tested before the timeout.
                if (bus.bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        ld_word_d  = bus.bus_rdata;
                        ld_a_d     = a_q;
                        ld_op_d    = op_q;
                        ld_valid_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == WAIT_LAST) begin
                    bus_req_d = 1'b0;
                    exc_bus_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            op_q        <= '0;
            a_q         <= '0;
            ld_word_q   <= '0;
            ld_a_q      <= '0;
            ld_op_q     <= '0;
            ld_valid_q  <= 1'b0;
            exc_adel_q  <= 1'b0;
            exc_ades_q  <= 1'b0;
            exc_bus_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            op_q        <= op_d;
            a_q         <= a_d;
            ld_word_q   <= ld_word_d;
            ld_a_q      <= ld_a_d;
            ld_op_q     <= ld_op_d;
            ld_valid_q  <= ld_valid_d;
            exc_adel_q  <= exc_adel_d;
            exc_ades_q  <= exc_ades_d;
            exc_bus_q   <= exc_bus_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.ld_word   = ld_word_q;
    assign bus.ld_a      = ld_a_q;
    assign bus.ld_op     = ld_op_q;
    assign bus.ld_valid  = ld_valid_q;
    assign bus.exc_adel  = exc_adel_q;
    assign bus.exc_ades  = exc_ades_q;
    assign bus.exc_bus   = exc_bus_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios followed by random
// accesses, each checked against a transaction-level model.
module tb_mem_access_unit;

    localparam int WAIT_MAX = 4;

    logic clk;
    logic rst_n;

    mem_access_unit_if intf();

    mem_access_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the load-result registers
    logic [31:0] m_ld_word;
    logic [1:0]  m_ld_a;
    logic [2:0]  m_ld_op;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Access size in bytes; undefined op codes are words.
    function automatic int size_of(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 1;
        if (op == 3'd3 || op == 3'd4) return 2;
        return 4;
    endfunction

    function automatic bit is_aligned(input logic [2:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) % size_of(op)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] op, input logic [31:0] addr);
        int sz;
        if (!we) return 4'hF;
        sz = size_of(op);
        return 4'(((1 << sz) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = size_of(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    task automatic drive_req(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        intf.req_valid = 1'b1;
        intf.req_we    = we;
        intf.req_op    = op;
        intf.req_addr  = addr;
        intf.req_wdata = wd;
    endtask

    // Aligned access. ack_delay = BUSY cycles without ack before ack;
    // ack_delay >= WAIT_MAX never acks.
    task automatic run_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_delay, input logic [31:0] rdata);
        bit acked;
        int busy_exp;
        int stall_cnt;
        logic early_pulse;
        acked     = ack_delay < WAIT_MAX;
        busy_exp  = acked ? ack_delay + 1 : WAIT_MAX;
        stall_cnt = 0;
        early_pulse = 1'b0;
        @(posedge clk); #1;
        drive_req(we, op, addr, wd);
        intf.bus_ack   = 1'b0;
        intf.bus_rdata = rdata;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!intf.stall) break;
            stall_cnt++;
            if (k == 0) begin
                chk("idle_bus_req", 32'(intf.bus_req), 32'(1'b0));
            end else begin
                if (k == 1) begin
                    chk("bus_req",   32'(intf.bus_req), 32'(1'b1));
                    chk("bus_we",    32'(intf.bus_we), 32'(we));
                    chk("bus_addr",  intf.bus_addr, {addr[31:2], 2'b00});
                    chk("bus_be",    32'(intf.bus_be), 32'(model_be(we, op, addr)));
                    if (we) chk("bus_wdata", intf.bus_wdata, model_wdata(op, wd));
                end
                intf.bus_ack = ((k - 1) == ack_delay);
            end
            if (intf.ld_valid || intf.exc_bus || intf.exc_adel || intf.exc_ades) early_pulse = 1'b1;
        end
        // DONE cycle
        intf.bus_ack   = 1'b0;
        intf.req_valid = 1'b0;
        chk("stall_cycles", 32'(stall_cnt), 32'(busy_exp + 1));
        chk("early_pulse",  32'(early_pulse), 32'(1'b0));
        chk("done_bus_req", 32'(intf.bus_req), 32'(1'b0));
        chk("ld_valid",     32'(intf.ld_valid), 32'(!we && acked));
        chk("exc_bus",      32'(intf.exc_bus), 32'(!acked));
        if (!we && acked) begin
            m_ld_word = rdata;
            m_ld_a    = addr[1:0];
            m_ld_op   = op;
        end
        chk("ld_word", intf.ld_word, m_ld_word);
        chk("ld_a",    32'(intf.ld_a), 32'(m_ld_a));
        chk("ld_op",   32'(intf.ld_op), 32'(m_ld_op));
        @(negedge clk);
        chk("pulse_once", 32'({intf.ld_valid, intf.exc_bus}), 32'(0));
        $display("txn we=%0d op=%0d addr=0x%08h wdata=0x%08h ack_delay=%0d stall=%0d ld_word=0x%08h",
                 we, op, addr, wd, ack_delay, stall_cnt, intf.ld_word);
    endtask

    task automatic run_misaligned(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        drive_req(we, op, addr, wd);
        intf.bus_ack = 1'($urandom % 2);   // ack outside BUSY must be ignored
        @(negedge clk);
        chk("mis_stall",   32'(intf.stall), 32'(1'b0));
        chk("mis_bus_req", 32'(intf.bus_req), 32'(1'b0));
        @(posedge clk); #1;
        intf.req_valid = 1'b0;
        intf.bus_ack   = 1'b0;
        @(negedge clk);
        chk("exc_adel",     32'(intf.exc_adel), 32'(!we));
        chk("exc_ades",     32'(intf.exc_ades), 32'(we));
        chk("mis_bus_req2", 32'(intf.bus_req), 32'(1'b0));
        chk("mis_ld_valid", 32'(intf.ld_valid), 32'(1'b0));
        chk("mis_ld_word",  intf.ld_word, m_ld_word);
        @(negedge clk);
        chk("exc_once", 32'({intf.exc_adel, intf.exc_ades}), 32'(0));
        $display("txn misaligned we=%0d op=%0d addr=0x%08h adel=%0d ades=%0d", we, op, addr, !we, we);
    endtask

    initial begin
        rst_n          = 1'b0;
        intf.req_valid = 1'b0;
        intf.req_we    = 1'b0;
        intf.req_op    = 3'd0;
        intf.req_addr  = '0;
        intf.req_wdata = '0;
        intf.bus_rdata = '0;
        intf.bus_ack   = 1'b0;
        m_ld_word = '0;
        m_ld_a    = '0;
        m_ld_op   = '0;

        repeat (3) @(negedge clk);
        chk("rst_bus_req",  32'(intf.bus_req), 32'(1'b0));
        chk("rst_bus_be",   32'(intf.bus_be), 32'(0));
        chk("rst_bus_addr", intf.bus_addr, 32'(0));
        chk("rst_ld_word",  intf.ld_word, 32'(0));
        chk("rst_ld_valid", 32'(intf.ld_valid), 32'(1'b0));
        chk("rst_stall",    32'(intf.stall), 32'(1'b0));
        rst_n = 1'b1;

        // Directed scenarios
        run_access(1'b0, 3'd0, 32'h0000_0100, 32'h0,          2,  32'hDEAD_BEEF);
        run_access(1'b1, 3'd1, 32'h0000_0103, 32'h0000_00A5, 1,  32'h1111_1111);
        run_access(1'b1, 3'd3, 32'h0000_0102, 32'h0000_1234, 0,  32'h2222_2222);
        run_misaligned(1'b0, 3'd4, 32'h0000_0101, 32'h0);
        run_misaligned(1'b1, 3'd0, 32'h0000_0102, 32'h5555_AAAA);
        run_access(1'b0, 3'd0, 32'h0000_0104, 32'h0, 99, 32'h3333_3333);
        run_access(1'b0, 3'd0, 32'h0000_0108, 32'h0, WAIT_MAX - 1, 32'hCAFE_F00D);
        run_access(1'b0, 3'd2, 32'h0000_0203, 32'h0, 1, 32'h89AB_CDEF);

        // Reset in the middle of a BUSY access
        @(posedge clk); #1;
        drive_req(1'b0, 3'd0, 32'h0000_0200, 32'h0);
        intf.bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_bus_req", 32'(intf.bus_req), 32'(1'b1));
        #2 rst_n = 1'b0;
        #1 chk("async_rst_bus_req", 32'(intf.bus_req), 32'(1'b0));
        intf.req_valid = 1'b0;
        m_ld_word = '0;
        m_ld_a    = '0;
        m_ld_op   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ld_word", intf.ld_word, m_ld_word);
        chk("post_rst_bus_req", 32'(intf.bus_req), 32'(1'b0));
        run_access(1'b0, 3'd0, 32'h0000_0300, 32'h0, 1, 32'h0BAD_F00D);

        // Random accesses
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [2:0]  op;
            logic [31:0] addr, wd, rd;
            int          dly;
            we   = 1'($urandom % 2);
            op   = 3'($urandom_range(0, 7));
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            dly  = $urandom_range(0, 5);
            if (is_aligned(op, addr)) run_access(we, op, addr, wd, dly, rd);
            else                      run_misaligned(we, op, addr, wd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
